// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add 32x32->64 multiplier; define MUL_EARLY_EXIT_EN for data-dependent early exit
module mul_iter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             sign,
    input  logic             flush_exception,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi,
    output logic             stall_multiplier,
    output logic             ready
);
    localparam int PW = 2 * WIDTH;
    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d, prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PW-1:0]    pp, result;
    logic             calc_last, fire;

    assign a_mag  = (sign & multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign b_mag  = (sign & multiplier[WIDTH-1]) ? -multiplier : multiplier;
    assign pp     = PW'(b_q[STEP-1:0]) * PW'(a_q);
    assign result = neg_q ? -acc_q : acc_q;
`ifdef MUL_EARLY_EXIT_EN
    assign calc_last = (b_q >> STEP) == '0;
`else
    assign calc_last = cnt_q == CW'(N - 1);
`endif
    // A flush in the DONE cycle suppresses both the pulse and the result
    assign fire                     = (state_q == DONE) & ~flush_exception;
    assign ready                    = fire;
    assign stall_multiplier         = (state_q == IDLE & en & ~flush_exception) | (state_q == CALC);
    assign {product_hi, product_lo} = fire ? result : prod_q;

    // Next-state: accept in IDLE, one STEP-bit chunk per CALC cycle, publish in DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        prod_d  = prod_q;
        if (flush_exception) begin
            state_d = IDLE;
        end else if (state_q == IDLE && en) begin
            state_d = CALC;
            a_d     = a_mag;
            b_d     = b_mag;
            neg_d   = sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == CALC) begin
            acc_d   = acc_q + (pp << (cnt_q * STEP));
            b_d     = b_q >> STEP;
            cnt_d   = cnt_q + CW'(1);
            state_d = calc_last ? DONE : CALC;
        end else if (state_q == DONE) begin
            state_d = IDLE;
            prod_d  = result;
        end
    end

    // State and datapath registers; reset outranks flush and requests
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
        end
    end
endmodule
